cpu_controller: RTL and testbench
=================================

# cpu_controller

Instruction sequencer for the 8-bit RISC CPU. Drives a fixed eight-phase fetch/execute cycle and decodes the current `opcode` (from the instruction register) and the ALU `zero` flag into memory, register-load and program-counter strobes. One instruction completes every eight clocks until a HLT instruction freezes the machine. Sits beside the ALU, instruction register, accumulator, PC and memory in the CPU top level.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter (only with `CTRL_PERF_EN`).

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  opcode_t (3)  current instruction opcode from the IR (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP).
- `zero`  in  1  accumulator-zero flag from the ALU.
- `phase`  out  3  current phase, 0..7.
- `mem_rd`  out  1  memory read enable.
- `load_ir`  out  1  load instruction register.
- `inc_pc`  out  1  increment program counter.
- `load_pc`  out  1  load PC from operand address.
- `load_ac`  out  1  load accumulator from ALU `out`.
- `mem_wr`  out  1  memory write enable.
- `halt`  out  1  CPU halted; sticky until reset.
- `instr_cnt`  out  CNT_W  retired-instruction count (only with `CTRL_PERF_EN`).

## Operation
- Phase register counts 0..7, +1 per clock, 7 wraps to 0. Names: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Strobe decode (combinational from `phase`, `opcode`, `zero`, halt state; all others 0):
  - phase 0: none.
  - phase 1: `mem_rd`.
  - phase 2: `mem_rd`, `load_ir`.
  - phase 3: `mem_rd`, `load_ir`.
  - phase 4: `inc_pc` unless opcode=HLT.
  - phase 5: `mem_rd` if ALUOP.
  - phase 6: `mem_rd` if ALUOP; `inc_pc` if SKZ and `zero`; `load_pc` if JMP.
  - phase 7: `mem_rd` and `load_ac` if ALUOP; `load_pc` if JMP; `mem_wr` if STO.
- Halt state machine: RUN, HALTED. In RUN at phase 4 with opcode=HLT, next clock enters HALTED. In HALTED: `halt`=1, phase holds at 5, every strobe except `halt` forced 0, `opcode`/`zero` ignored. Exit only via `rst`.
- `halt` is registered; it does not assert during phase 4 itself.
- Opcodes outside the enum cannot occur (opcode_t is 3-bit, fully populated).

## Timing
- Reset (async assert, sync effect at deassert): `phase`=0, state RUN, `halt`=0, all strobes 0 (phase 0 decode), `instr_cnt`=0.
- Reset mid-instruction or while HALTED: immediate return to phase 0/RUN; no partial strobe held.
- First clock after `rst` deassert advances phase 0->1.
- Strobes are valid for exactly one full clock (the phase in which they decode); memory/registers sample on the following posedge. ALU `out` updates on the negedge inside phase 6, so `load_ac` in phase 7 captures it.
- `opcode` must be stable from phase 4 through 7 (IR reloads only in phases 2-3).
- SKZ taken: two `inc_pc` pulses per instruction (phases 4 and 6) -> next instruction skipped.
- Latency: 8 clocks per instruction; HLT seen at phase 4 -> `halt`=1 one clock later.

## Configuration
- `CTRL_PERF_EN` defined: `instr_cnt` port and counter present. Increments on each 7->0 phase transition in RUN; wraps 2^CNT_W-1 -> 0; frozen in HALTED (HLT is not counted); cleared by `rst`.
- Undefined: no `instr_cnt` port, no counter logic; all other behaviour identical.

## Test plan
- Reset: assert `rst` mid-phase 5 with ADD -> `phase`=0, all strobes 0, `halt`=0 while asserted; phase=1 one clock after release.
- ADD for 8 clocks -> `mem_rd`=1 in phases 1,2,3,5,6,7; `load_ir` in 2,3; `inc_pc` in 4; `load_ac` in 7 only; `mem_wr`/`load_pc` never.
- STO -> `mem_wr`=1 only in phase 7, `mem_rd`=0 in 5-7; JMP -> `load_pc`=1 in phases 6 and 7.
- SKZ with `zero`=1 -> `inc_pc` in phases 4 and 6; with `zero`=0 -> phase 4 only.
- HLT -> no `inc_pc` in phase 4; `halt`=1 from next clock, `phase` stuck at 5 and all strobes 0 for 20+ clocks; `rst` pulse restores phase 0, `halt`=0.
- `CTRL_PERF_EN`, CNT_W=4: run 17 ADD instructions -> `instr_cnt` reads 15 then 0 then 1; subsequent HLT leaves count unchanged.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller -- instruction sequencer for the 8-bit RISC CPU.
//
// Steps through a fixed eight-phase fetch/execute cycle and decodes the
// current opcode and the ALU zero flag into memory, register-load and PC
// strobes. A HLT seen in phase 4 freezes the machine (phase held at 5,
// all strobes low, halt high) until rst.
//
// Optional feature macro: CTRL_PERF_EN -- adds the instr_cnt port and a
// retired-instruction counter of width CNT_W.
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   opcode     in   current IR opcode (opcode_t)
//   zero       in   accumulator-zero flag
//   phase      out  current phase 0..7
//   mem_rd     out  memory read enable
//   load_ir    out  load instruction register
//   inc_pc     out  increment program counter
//   load_pc    out  load PC from operand address
//   load_ac    out  load accumulator from ALU
//   mem_wr     out  memory write enable
//   halt       out  CPU halted, sticky until rst
//   instr_cnt  out  retired-instruction count (CTRL_PERF_EN only)

package cpu_controller_pkg;
   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;
endpackage

module cpu_controller
   import cpu_controller_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  opcode_t          opcode,
   input  logic             zero,
   output logic [2:0]       phase,
   output logic             mem_rd,
   output logic             load_ir,
   output logic             inc_pc,
   output logic             load_pc,
   output logic             load_ac,
   output logic             mem_wr,
   output logic             halt
`ifdef CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   phase_t r_phase;
   phase_t w_phase_nxt;
   state_t r_state;
   state_t w_state_nxt;
   logic   w_aluop;

   assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= PH_INST_ADDR;
         r_state <= ST_RUN;
      end else begin
         r_phase <= w_phase_nxt;
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_phase_nxt = r_phase;
      w_state_nxt = r_state;
      mem_rd      = 1'b0;
      load_ir     = 1'b0;
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      load_ac     = 1'b0;
      mem_wr      = 1'b0;

      unique case (r_state)
         ST_RUN: begin
            w_phase_nxt = phase_t'(r_phase + 3'd1);
            // HLT advances to phase 5 on the same edge, which is then held.
            if (r_phase == PH_OP_ADDR && opcode == OP_HLT)
               w_state_nxt = ST_HALTED;

            unique case (r_phase)
               PH_INST_ADDR: ;
               PH_INST_FETCH: mem_rd = 1'b1;
               PH_INST_LOAD, PH_IDLE: begin
                  mem_rd  = 1'b1;
                  load_ir = 1'b1;
               end
               PH_OP_ADDR: inc_pc = (opcode != OP_HLT);
               PH_OP_FETCH: mem_rd = w_aluop;
               PH_ALU_OP: begin
                  mem_rd  = w_aluop;
                  inc_pc  = (opcode == OP_SKZ) && zero;
                  load_pc = (opcode == OP_JMP);
               end
               PH_STORE: begin
                  mem_rd  = w_aluop;
                  load_ac = w_aluop;
                  load_pc = (opcode == OP_JMP);
                  mem_wr  = (opcode == OP_STO);
               end
            endcase
         end
         ST_HALTED: ;
      endcase
   end

   assign phase = r_phase;
   assign halt  = (r_state == ST_HALTED);

`ifdef CTRL_PERF_EN
   logic [CNT_W-1:0] r_instr_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_instr_cnt <= '0;
      else if (r_state == ST_RUN && r_phase == PH_STORE)
         r_instr_cnt <= r_instr_cnt + 1'b1;
   end

   assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller -- self-checking bench for cpu_controller.
// Expected outputs come from a small cycle model; each cycle the expected
// vector is queued when inputs are driven and popped when outputs are sampled.
// With CTRL_PERF_EN defined the DUT is built with CNT_W=4.

module tb_cpu_controller;
   import cpu_controller_pkg::*;

   logic       clk;
   logic       rst;
   opcode_t    opcode;
   logic       zero;
   logic [2:0] phase;
   logic       mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt;
`ifdef CTRL_PERF_EN
   logic [3:0] instr_cnt;
`endif

   cpu_controller #(.CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .zero      (zero),
      .phase     (phase),
      .mem_rd    (mem_rd),
      .load_ir   (load_ir),
      .inc_pc    (inc_pc),
      .load_pc   (load_pc),
      .load_ac   (load_ac),
      .mem_wr    (mem_wr),
      .halt      (halt)
`ifdef CTRL_PERF_EN
      ,
      .instr_cnt (instr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // model state
   logic [2:0] m_phase;
   logic       m_halted;
   logic [3:0] m_cnt;

   logic [9:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {phase, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt}
   function automatic logic [9:0] model_out();
      logic aluop;
      logic rd, ir, inc, lpc, lac, wr;
      if (m_halted) return {m_phase, 6'b0, 1'b1};
      aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
              (opcode == OP_XOR) || (opcode == OP_LDA);
      rd  = (m_phase >= 3'd1 && m_phase <= 3'd3) || (aluop && m_phase >= 3'd5);
      ir  = (m_phase == 3'd2) || (m_phase == 3'd3);
      inc = (m_phase == 3'd4 && opcode != OP_HLT) ||
            (m_phase == 3'd6 && opcode == OP_SKZ && zero);
      lpc = (opcode == OP_JMP) && (m_phase == 3'd6 || m_phase == 3'd7);
      lac = aluop && (m_phase == 3'd7);
      wr  = (opcode == OP_STO) && (m_phase == 3'd7);
      return {m_phase, rd, ir, inc, lpc, lac, wr, 1'b0};
   endfunction

   task automatic model_reset();
      m_phase  = 3'd0;
      m_halted = 1'b0;
      m_cnt    = 4'd0;
   endtask

   task automatic model_advance();
      if (!m_halted) begin
         if (m_phase == 3'd4 && opcode == OP_HLT) m_halted = 1'b1;
         if (m_phase == 3'd7) m_cnt = m_cnt + 4'd1;
         m_phase = m_phase + 3'd1;
      end
   endtask

   // Called just after a negedge with inputs settled.
   task automatic cycle();
      logic [9:0] got, e;
      string tag;
      exp_q.push_back(model_out());
      tag = $sformatf("%s_p%0d%s", opcode.name(), m_phase, m_halted ? "_halted" : "");
      #1;
      got = {phase, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt};
      e = exp_q.pop_front();
      check(tag, {22'd0, got}, {22'd0, e});
`ifdef CTRL_PERF_EN
      check({tag, "_cnt"}, {28'd0, instr_cnt}, {28'd0, m_cnt});
`endif
      @(posedge clk);
      if (!rst) model_advance();
      @(negedge clk);
   endtask

   task automatic run_instr(input opcode_t op, input logic z);
      opcode = op;
      zero   = z;
      repeat (8) cycle();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      model_reset();
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      opcode = OP_ADD;
      zero   = 1'b0;
      model_reset();
      @(negedge clk);

      // reset held: phase 0, nothing asserted
      cycle();
      cycle();
      rst = 1'b0;

      // basic instruction mix
      run_instr(OP_ADD, 1'b0);
      run_instr(OP_STO, 1'b0);
      run_instr(OP_JMP, 1'b1);
      run_instr(OP_SKZ, 1'b1);
      run_instr(OP_SKZ, 1'b0);
      run_instr(OP_AND, 1'b1);
      run_instr(OP_XOR, 1'b0);
      run_instr(OP_LDA, 1'b1);

      // reset in the middle of phase 5
      opcode = OP_ADD;
      zero   = 1'b0;
      repeat (5) cycle();
      check("pre_rst_phase", {29'd0, phase}, 32'd5);
      reset_pulse();
      cycle();
      check("rst_rel_phase", {29'd0, phase}, 32'd1);
      repeat (7) cycle();

      // 17 instructions: counter (CNT_W=4) passes 15 -> 0 -> 1
      reset_pulse();
      repeat (15) run_instr(OP_ADD, 1'b0);
`ifdef CTRL_PERF_EN
      check("cnt_15", {28'd0, instr_cnt}, 32'd15);
`endif
      run_instr(OP_ADD, 1'b0);
`ifdef CTRL_PERF_EN
      check("cnt_wrap0", {28'd0, instr_cnt}, 32'd0);
`endif
      run_instr(OP_ADD, 1'b0);
`ifdef CTRL_PERF_EN
      check("cnt_1", {28'd0, instr_cnt}, 32'd1);
`endif

      // HLT freezes the machine; inputs toggled while halted are ignored
      run_instr(OP_HLT, 1'b0);
      check("halt_set", {31'd0, halt}, 32'd1);
      for (int i = 0; i < 24; i++) begin
         opcode = opcode_t'(i[2:0]);
         zero   = i[0];
         cycle();
      end
      check("halt_phase", {29'd0, phase}, 32'd5);
`ifdef CTRL_PERF_EN
      check("cnt_frozen", {28'd0, instr_cnt}, 32'd1);
`endif

      // reset releases the halt
      opcode = OP_ADD;
      zero   = 1'b0;
      reset_pulse();
      check("halt_clr", {31'd0, halt}, 32'd0);
      run_instr(OP_SKZ, 1'b1);
      run_instr(OP_STO, 1'b0);

      if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
